// File: rtl/usb_xfer_ctrl_pkg.sv
// Shared constants and types for the USB transfer controller.
package usb_xfer_ctrl_pkg;

  localparam int unsigned NumEp = 4;
  localparam int unsigned EpW   = 2;

  // PID nibbles as seen on the wire.
  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  // Two-bit DATA type codes exchanged with the packet layer.
  localparam logic [1:0] DataType0 = 2'b00;
  localparam logic [1:0] DataType1 = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StInReq,
    StInWait,
    StOutWait,
    StOutData,
    StHsReq
  } state_e;

  // Pending handshake, encoded by its PID.
  typedef enum logic [3:0] {
    HsAck   = PidAck,
    HsNak   = PidNak,
    HsStall = PidStall
  } hs_e;

  function automatic logic [1:0] data_type_code(input logic toggle);
    return toggle ? DataType1 : DataType0;
  endfunction

endpackage

// File: rtl/usb_xfer_ctrl_if.sv
// Packet-layer token/data/handshake bundle between the packet engine and the controller.
interface usb_xfer_ctrl_if;

  logic       rx_in_token;
  logic       rx_out_token;
  logic       rx_setup_token;
  logic       rx_ack;
  logic       rx_data;
  logic [6:0] rx_addr;
  logic [3:0] rx_endpoint;
  logic [1:0] rx_data_type;
  logic       rx_data_tvalid;
  logic       rx_data_tready;
  logic       rx_data_tlast;
  logic       rx_data_error;
  logic       tx_ready;
  logic       tx_ack;
  logic       tx_nack;
  logic       tx_stall;
  logic       tx_data;
  logic       tx_data_null;
  logic [1:0] tx_data_type;

  // Packet layer side.
  modport master (
    output rx_in_token, rx_out_token, rx_setup_token, rx_ack, rx_data,
    output rx_addr, rx_endpoint, rx_data_type,
    output rx_data_tvalid, rx_data_tready, rx_data_tlast, rx_data_error,
    output tx_ready,
    input  tx_ack, tx_nack, tx_stall, tx_data, tx_data_null, tx_data_type
  );

  // Transfer controller side.
  modport slave (
    input  rx_in_token, rx_out_token, rx_setup_token, rx_ack, rx_data,
    input  rx_addr, rx_endpoint, rx_data_type,
    input  rx_data_tvalid, rx_data_tready, rx_data_tlast, rx_data_error,
    input  tx_ready,
    output tx_ack, tx_nack, tx_stall, tx_data, tx_data_null, tx_data_type
  );

endinterface

// File: rtl/usb_toggle_bank.sv
// Per-endpoint IN and OUT data toggle bits with set/flip on the selected endpoint.
module usb_toggle_bank
  import usb_xfer_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [EpW-1:0]   sel,
  input  logic             in_set,
  input  logic             in_flip,
  input  logic             out_set,
  input  logic             out_flip,
  output logic [NumEp-1:0] in_tog,
  output logic [NumEp-1:0] out_tog
);

  logic [NumEp-1:0] in_tog_q;
  logic [NumEp-1:0] out_tog_q;

  // Update the selected endpoint; set wins over flip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_tog_q  <= '0;
      out_tog_q <= '0;
    end else begin
      if (in_set) begin
        in_tog_q[sel] <= 1'b1;
      end else if (in_flip) begin
        in_tog_q[sel] <= ~in_tog_q[sel];
      end
      if (out_set) begin
        out_tog_q[sel] <= 1'b1;
      end else if (out_flip) begin
        out_tog_q[sel] <= ~out_tog_q[sel];
      end
    end
  end

  assign in_tog  = in_tog_q;
  assign out_tog = out_tog_q;

endmodule

// File: rtl/usb_xfer_ctrl.sv
// USB device transfer controller: sequences IN/OUT/SETUP transactions for EP0..EP3.
module usb_xfer_ctrl
  import usb_xfer_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           dev_addr,
  usb_xfer_ctrl_if.slave       pkt,
  input  logic [NumEp-1:0]     in_ep_valid,
  input  logic [NumEp-1:0]     in_ep_null,
  input  logic [NumEp-1:0]     out_ep_ready,
  input  logic [NumEp-1:0]     ep_stall,
  output logic [EpW-1:0]       cur_ep,
  output logic                 in_done,
  output logic                 out_commit,
  output logic                 out_discard
);

  state_e           state_q;
  hs_e              hs_q;
  logic [EpW-1:0]   cur_ep_q;
  logic             setup_q;
  logic [7:0]       cnt_q;
  logic             tx_ack_q, tx_nack_q, tx_stall_q, tx_data_q, tx_data_null_q;
  logic [1:0]       tx_data_type_q;
  logic             in_done_q, out_commit_q, out_discard_q;
  logic [NumEp-1:0] in_tog, out_tog;

  logic addr_ok, tok_any, setup_hit, in_hit, out_hit, timeout, last_beat;
  logic od_send, od_commit, od_discard;
  hs_e  od_hs;
  logic in_set, in_flip, out_set, out_flip;

  // Only the toggle bit of the type code matters; DATA2/MDATA are not used here.
  logic unused_data_type_lsb;
  assign unused_data_type_lsb = pkt.rx_data_type[0];

  // Token qualification, timeout and end-of-payload detection.
  always_comb begin
    addr_ok   = (pkt.rx_addr == dev_addr) && (pkt.rx_endpoint[3:EpW] == '0);
    tok_any   = pkt.rx_in_token | pkt.rx_out_token | pkt.rx_setup_token;
    setup_hit = pkt.rx_setup_token & addr_ok;
    in_hit    = pkt.rx_in_token & addr_ok;
    out_hit   = pkt.rx_out_token & addr_ok;
    timeout   = (cnt_q == 8'(TIMEOUT - 1));
    last_beat = pkt.rx_data_tvalid & pkt.rx_data_tready & pkt.rx_data_tlast;
  end

  // OUT/SETUP completion decision and toggle-bank updates; a SETUP abort suppresses all.
  always_comb begin
    od_send    = 1'b0;
    od_commit  = 1'b0;
    od_discard = 1'b0;
    od_hs      = HsAck;
    in_set     = 1'b0;
    in_flip    = 1'b0;
    out_set    = 1'b0;
    out_flip   = 1'b0;
    if (!setup_hit) begin
      if (state_q == StInWait && pkt.rx_ack) begin
        in_flip = 1'b1;
      end
      if (state_q == StOutData && last_beat) begin
        if (pkt.rx_data_error) begin
          od_discard = 1'b1;
        end else if (setup_q) begin
          od_send   = 1'b1;
          od_commit = 1'b1;
          in_set    = 1'b1;
          out_set   = 1'b1;
        end else if (ep_stall[cur_ep_q]) begin
          od_send    = 1'b1;
          od_hs      = HsStall;
          od_discard = 1'b1;
        end else if (!out_ep_ready[cur_ep_q]) begin
          od_send    = 1'b1;
          od_hs      = HsNak;
          od_discard = 1'b1;
        end else if (pkt.rx_data_type[1] != out_tog[cur_ep_q]) begin
          // Retransmission of data already accepted: ACK again, drop the copy.
          od_send    = 1'b1;
          od_discard = 1'b1;
        end else begin
          od_send   = 1'b1;
          od_commit = 1'b1;
          out_flip  = 1'b1;
        end
      end
    end
  end

  usb_toggle_bank u_toggle_bank (
    .clk      (clk),
    .rst      (rst),
    .sel      (cur_ep_q),
    .in_set   (in_set),
    .in_flip  (in_flip),
    .out_set  (out_set),
    .out_flip (out_flip),
    .in_tog   (in_tog),
    .out_tog  (out_tog)
  );

  // Transaction FSM with registered request and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      hs_q           <= HsAck;
      cur_ep_q       <= '0;
      setup_q        <= 1'b0;
      cnt_q          <= '0;
      tx_ack_q       <= 1'b0;
      tx_nack_q      <= 1'b0;
      tx_stall_q     <= 1'b0;
      tx_data_q      <= 1'b0;
      tx_data_null_q <= 1'b0;
      tx_data_type_q <= DataType0;
      in_done_q      <= 1'b0;
      out_commit_q   <= 1'b0;
      out_discard_q  <= 1'b0;
    end else begin
      tx_ack_q       <= 1'b0;
      tx_nack_q      <= 1'b0;
      tx_stall_q     <= 1'b0;
      tx_data_q      <= 1'b0;
      tx_data_null_q <= 1'b0;
      tx_data_type_q <= DataType0;
      in_done_q      <= 1'b0;
      out_commit_q   <= 1'b0;
      out_discard_q  <= 1'b0;
      cnt_q          <= '0;
      if (setup_hit) begin
        state_q  <= StOutWait;
        setup_q  <= 1'b1;
        cur_ep_q <= pkt.rx_endpoint[EpW-1:0];
      end else begin
        case (state_q)
          StIdle: begin
            if (in_hit) begin
              state_q  <= StInReq;
              setup_q  <= 1'b0;
              cur_ep_q <= pkt.rx_endpoint[EpW-1:0];
            end else if (out_hit) begin
              state_q  <= StOutWait;
              setup_q  <= 1'b0;
              cur_ep_q <= pkt.rx_endpoint[EpW-1:0];
            end
          end
          StInReq: begin
            if (pkt.tx_ready) begin
              if (ep_stall[cur_ep_q]) begin
                tx_stall_q <= 1'b1;
                state_q    <= StIdle;
              end else if (!in_ep_valid[cur_ep_q]) begin
                tx_nack_q <= 1'b1;
                state_q   <= StIdle;
              end else begin
                tx_data_q      <= 1'b1;
                tx_data_type_q <= data_type_code(in_tog[cur_ep_q]);
                tx_data_null_q <= in_ep_null[cur_ep_q];
                state_q        <= StInWait;
              end
            end
          end
          StInWait: begin
            if (pkt.rx_ack) begin
              in_done_q <= 1'b1;
              state_q   <= StIdle;
            end else if (tok_any || timeout) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StOutWait: begin
            if (pkt.rx_data) begin
              state_q <= StOutData;
            end else if (timeout) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StOutData: begin
            if (last_beat) begin
              out_commit_q  <= od_commit;
              out_discard_q <= od_discard;
              hs_q          <= od_hs;
              state_q       <= od_send ? StHsReq : StIdle;
            end
          end
          StHsReq: begin
            if (pkt.tx_ready) begin
              case (hs_q)
                HsAck:   tx_ack_q   <= 1'b1;
                HsNak:   tx_nack_q  <= 1'b1;
                HsStall: tx_stall_q <= 1'b1;
                default: ;
              endcase
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign pkt.tx_ack       = tx_ack_q;
  assign pkt.tx_nack      = tx_nack_q;
  assign pkt.tx_stall     = tx_stall_q;
  assign pkt.tx_data      = tx_data_q;
  assign pkt.tx_data_null = tx_data_null_q;
  assign pkt.tx_data_type = tx_data_type_q;
  assign cur_ep           = cur_ep_q;
  assign in_done          = in_done_q;
  assign out_commit       = out_commit_q;
  assign out_discard      = out_discard_q;

endmodule

// File: tb/tb_usb_xfer_ctrl.sv
// Directed self-checking bench for usb_xfer_ctrl.
module tb_usb_xfer_ctrl;
  import usb_xfer_ctrl_pkg::*;

  localparam logic [6:0] Addr = 7'h05;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] dev_addr = Addr;
  logic [3:0] in_ep_valid = 4'hF, in_ep_null = 4'h0, out_ep_ready = 4'hF, ep_stall = 4'h0;
  logic [1:0] cur_ep;
  logic       in_done, out_commit, out_discard;

  usb_xfer_ctrl_if pkt ();

  usb_xfer_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .dev_addr     (dev_addr),
    .pkt          (pkt),
    .in_ep_valid  (in_ep_valid),
    .in_ep_null   (in_ep_null),
    .out_ep_ready (out_ep_ready),
    .ep_stall     (ep_stall),
    .cur_ep       (cur_ep),
    .in_done      (in_done),
    .out_commit   (out_commit),
    .out_discard  (out_discard)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pulse counters kept by the monitor, plus snapshots taken before each step.
  int n_ack = 0, n_nak = 0, n_stall = 0, n_data = 0, n_done = 0, n_commit = 0, n_discard = 0;
  int n_multi = 0;
  int b_ack, b_nak, b_stall, b_data, b_done, b_commit, b_discard;
  int last_type = -1, last_null = -1;

  always @(negedge clk) begin
    if (pkt.tx_ack) n_ack++;
    if (pkt.tx_nack) n_nak++;
    if (pkt.tx_stall) n_stall++;
    if (pkt.tx_data) begin
      n_data++;
      last_type = int'(pkt.tx_data_type);
      last_null = int'(pkt.tx_data_null);
    end
    if (in_done) n_done++;
    if (out_commit) n_commit++;
    if (out_discard) n_discard++;
    if (int'(pkt.tx_ack) + int'(pkt.tx_nack) + int'(pkt.tx_stall) + int'(pkt.tx_data) > 1)
      n_multi++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic snap();
    b_ack = n_ack; b_nak = n_nak; b_stall = n_stall; b_data = n_data;
    b_done = n_done; b_commit = n_commit; b_discard = n_discard;
  endtask

  // kind: 0 = IN, 1 = OUT, 2 = SETUP
  task automatic token(input int kind, input logic [6:0] a, input logic [3:0] e);
    pkt.rx_addr     = a;
    pkt.rx_endpoint = e;
    pkt.rx_in_token    = (kind == 0);
    pkt.rx_out_token   = (kind == 1);
    pkt.rx_setup_token = (kind == 2);
    tick();
    pkt.rx_in_token = 1'b0; pkt.rx_out_token = 1'b0; pkt.rx_setup_token = 1'b0;
  endtask

  task automatic out_data(input logic [1:0] t, input logic err);
    pkt.rx_data = 1'b1;
    pkt.rx_data_type = t;
    tick();
    pkt.rx_data = 1'b0;
    pkt.rx_data_tvalid = 1'b1; pkt.rx_data_tready = 1'b1; pkt.rx_data_tlast = 1'b1;
    pkt.rx_data_error = err;
    tick();
    pkt.rx_data_tvalid = 1'b0; pkt.rx_data_tready = 1'b0; pkt.rx_data_tlast = 1'b0;
    pkt.rx_data_error = 1'b0;
  endtask

  task automatic host_ack();
    pkt.rx_ack = 1'b1;
    tick();
    pkt.rx_ack = 1'b0;
  endtask

  task automatic chk_hs(input string tag, input int ack, input int nak, input int stl,
                        input int commit, input int discard);
    check({tag, "_ack"}, n_ack - b_ack, ack);
    check({tag, "_nak"}, n_nak - b_nak, nak);
    check({tag, "_stall"}, n_stall - b_stall, stl);
    check({tag, "_commit"}, n_commit - b_commit, commit);
    check({tag, "_discard"}, n_discard - b_discard, discard);
  endtask

  initial begin
    int n;
    pkt.rx_in_token = 1'b0; pkt.rx_out_token = 1'b0; pkt.rx_setup_token = 1'b0;
    pkt.rx_ack = 1'b0; pkt.rx_data = 1'b0;
    pkt.rx_addr = '0; pkt.rx_endpoint = '0; pkt.rx_data_type = '0;
    pkt.rx_data_tvalid = 1'b0; pkt.rx_data_tready = 1'b0; pkt.rx_data_tlast = 1'b0;
    pkt.rx_data_error = 1'b0;
    pkt.tx_ready = 1'b1;
    idle(3);

    // Reset state
    check("rst_cur_ep", int'(cur_ep), 0);
    check("rst_tx", int'({pkt.tx_ack, pkt.tx_nack, pkt.tx_stall, pkt.tx_data}), 0);
    check("rst_pulses", int'({in_done, out_commit, out_discard}), 0);
    check("rst_in_tog", int'(dut.u_toggle_bank.in_tog_q), 0);
    check("rst_out_tog", int'(dut.u_toggle_bank.out_tog_q), 0);
    rst = 1'b0;
    idle(2);

    // IN EP1: DATA0, ack, then DATA1
    snap();
    token(0, Addr, 4'd1);
    idle(4);
    check("in1_data", n_data - b_data, 1);
    check("in1_type", last_type, 0);
    check("in1_null", last_null, 0);
    check("in1_cur_ep", int'(cur_ep), 1);
    host_ack();
    idle(3);
    check("in1_done", n_done - b_done, 1);
    in_ep_null = 4'b0010;
    token(0, Addr, 4'd1);
    idle(4);
    check("in1b_type", last_type, 2);
    check("in1b_null", last_null, 1);
    in_ep_null = 4'h0;
    // A second IN aborts the wait unanswered; the next IN repeats DATA1.
    token(0, Addr, 4'd1);
    idle(2);
    check("in1_drop_idle", int'(dut.state_q), int'(StIdle));
    token(0, Addr, 4'd1);
    idle(4);
    check("in1c_type", last_type, 2);
    check("in1_done_total", n_done - b_done, 1);
    token(0, Addr, 4'd1);
    idle(2);

    // IN EP2: NAK when not valid, STALL when stalled
    snap();
    in_ep_valid = 4'b1011;
    token(0, Addr, 4'd2);
    idle(4);
    in_ep_valid = 4'hF;
    ep_stall = 4'b0100;
    token(0, Addr, 4'd2);
    idle(4);
    ep_stall = 4'h0;
    check("in2_nak", n_nak - b_nak, 1);
    check("in2_stall", n_stall - b_stall, 1);
    check("in2_no_data", n_data - b_data, 0);

    // OUT EP1: DATA0 with delayed tx_ready
    snap();
    pkt.tx_ready = 1'b0;
    token(1, Addr, 4'd1);
    out_data(DataType0, 1'b0);
    idle(5);
    check("out1_hold_ack", n_ack - b_ack, 0);
    check("out1_hold_state", int'(dut.state_q), int'(StHsReq));
    pkt.tx_ready = 1'b1;
    idle(3);
    chk_hs("out1a", 1, 0, 0, 1, 0);
    // Repeated DATA0: ACK but discard
    snap();
    token(1, Addr, 4'd1);
    out_data(DataType0, 1'b0);
    idle(4);
    chk_hs("out1b", 1, 0, 0, 0, 1);
    // DATA1 now in sequence
    snap();
    token(1, Addr, 4'd1);
    out_data(DataType1, 1'b0);
    idle(4);
    chk_hs("out1c", 1, 0, 0, 1, 0);
    // Endpoint not ready: NAK
    snap();
    out_ep_ready = 4'b1101;
    token(1, Addr, 4'd1);
    out_data(DataType0, 1'b0);
    idle(4);
    out_ep_ready = 4'hF;
    chk_hs("out1d", 0, 1, 0, 0, 1);

    // SETUP EP0: errored data, then retry on a stalled endpoint
    snap();
    token(2, Addr, 4'd0);
    out_data(DataType0, 1'b1);
    idle(4);
    chk_hs("setup_err", 0, 0, 0, 0, 1);
    snap();
    ep_stall = 4'b0001;
    token(2, Addr, 4'd0);
    out_data(DataType0, 1'b0);
    idle(4);
    ep_stall = 4'h0;
    chk_hs("setup_ok", 1, 0, 0, 1, 0);
    check("setup_in_tog0", int'(dut.u_toggle_bank.in_tog_q[0]), 1);
    check("setup_out_tog0", int'(dut.u_toggle_bank.out_tog_q[0]), 1);
    token(0, Addr, 4'd0);
    idle(4);
    check("setup_in_type", last_type, 2);
    host_ack();
    idle(2);

    // SETUP aborting a pending IN wait produces no pulses
    snap();
    token(0, Addr, 4'd2);
    idle(3);
    token(2, Addr, 4'd0);
    idle(3);
    check("abort_state", int'(dut.state_q), int'(StOutWait));
    check("abort_cur_ep", int'(cur_ep), 0);
    check("abort_done", n_done - b_done, 0);
    out_data(DataType0, 1'b0);
    idle(4);
    chk_hs("abort_setup", 1, 0, 0, 1, 0);

    // IN EP3 timeout: wait lasts TIMEOUT cycles, toggle unchanged
    snap();
    token(0, Addr, 4'd3);
    n = 0;
    while (dut.state_q != StInWait && n < 10) begin
      tick();
      n++;
    end
    check("to_enter", int'(n < 10), 1);
    n = 0;
    while (dut.state_q == StInWait && n < 400) begin
      tick();
      n++;
    end
    check("to_len", n, 255);
    check("to_done", n_done - b_done, 0);
    token(0, Addr, 4'd3);
    idle(4);
    check("to_type", last_type, 0);
    token(0, Addr, 4'd3);
    idle(2);

    // Reset during OUT_DATA with a final beat: no handshake afterwards
    token(1, Addr, 4'd1);
    pkt.rx_data = 1'b1;
    tick();
    pkt.rx_data = 1'b0;
    check("rst_mid_state", int'(dut.state_q), int'(StOutData));
    snap();
    rst = 1'b1;
    pkt.rx_data_tvalid = 1'b1; pkt.rx_data_tready = 1'b1; pkt.rx_data_tlast = 1'b1;
    tick();
    pkt.rx_data_tvalid = 1'b0; pkt.rx_data_tready = 1'b0; pkt.rx_data_tlast = 1'b0;
    tick();
    rst = 1'b0;
    idle(10);
    check("rst_mid_tx", (n_ack - b_ack) + (n_nak - b_nak) + (n_stall - b_stall)
          + (n_data - b_data), 0);
    check("rst_mid_idle", int'(dut.state_q), int'(StIdle));
    check("rst_mid_cur_ep", int'(cur_ep), 0);

    // Foreign address and out-of-range endpoint are ignored
    snap();
    token(0, 7'h06, 4'd1);
    token(1, 7'h06, 4'd1);
    token(0, Addr, 4'd5);
    token(2, Addr, 4'd5);
    idle(4);
    check("ign_cur_ep", int'(cur_ep), 0);
    check("ign_state", int'(dut.state_q), int'(StIdle));
    check("ign_data", n_data - b_data, 0);
    chk_hs("ign", 0, 0, 0, 0, 0);

    // EP1 IN toggle was 1 before reset; it must restart at DATA0
    token(0, Addr, 4'd1);
    idle(4);
    check("post_rst_type", last_type, 0);
    host_ack();
    idle(2);

    check("one_tx_per_cycle", n_multi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
